// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// mult/multu take 5 busy cycles, div/divu take 10. mthi/mtlo write in one cycle.
// Optional build macro MD_CANCEL_EN: when defined, md_cancel=1 blocks
// acceptance of any command in that cycle. Running operations are not affected.
module md_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        MDctrl,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              HILOsel,
   input  logic              md_cancel,
   output logic              start,
   output logic              busy,
   output logic [DATA_W-1:0] HI,
   output logic [DATA_W-1:0] LO,
   output logic [DATA_W-1:0] HILOout
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   // Full-width product; signed operands are sign-extended, unsigned zero-extended.
   function automatic logic [2*DATA_W-1:0] mul_full(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic                     sgn
   );
      logic signed [2*DATA_W-1:0] sa;
      logic signed [2*DATA_W-1:0] sb;
      logic        [2*DATA_W-1:0] ua;
      logic        [2*DATA_W-1:0] ub;
      sa = {{DATA_W{a[DATA_W-1]}}, a};
      sb = {{DATA_W{b[DATA_W-1]}}, b};
      ua = {{DATA_W{1'b0}}, a};
      ub = {{DATA_W{1'b0}}, b};
      if (sgn) mul_full = $unsigned(sa * sb);
      else     mul_full = ua * ub;
   endfunction

   // Returns {remainder, quotient}. Signed division truncates toward zero, so the
   // remainder follows the dividend's sign. The most-negative / -1 overflow case
   // is pinned to quotient=dividend, remainder=0 instead of relying on the host.
   function automatic logic [2*DATA_W-1:0] div_full(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic                     sgn
   );
      logic signed [DATA_W-1:0] sq;
      logic signed [DATA_W-1:0] sr;
      logic        [DATA_W-1:0] uq;
      logic        [DATA_W-1:0] ur;
      sq = '0;
      sr = '0;
      uq = '0;
      ur = '0;
      if (b != '0) begin
         if (sgn) begin
            if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
               sq = a;
               sr = '0;
            end else begin
               sq = a / b;
               sr = a % b;
            end
         end else begin
            uq = $unsigned(a) / $unsigned(b);
            ur = $unsigned(a) % $unsigned(b);
         end
      end
      div_full = sgn ? {sr, sq} : {ur, uq};
   endfunction

   logic                     accept;
   logic [2:0]               op_p0;
   logic signed [DATA_W-1:0] a_p0;
   logic signed [DATA_W-1:0] b_p0;
   logic [3:0]               cnt_p0;
   logic                     vld_p0;
   logic [2*DATA_W-1:0]      mul_res;
   logic [2*DATA_W-1:0]      div_res;

`ifdef MD_CANCEL_EN
   assign accept = ~vld_p0 & ~md_cancel;
`else
   logic unused_md_cancel;
   assign unused_md_cancel = md_cancel;
   assign accept = ~vld_p0;
`endif

   assign start   = accept & (MDctrl == OP_MULT || MDctrl == OP_MULTU ||
                              MDctrl == OP_DIV  || MDctrl == OP_DIVU);
   assign busy    = vld_p0;
   assign HILOout = HILOsel ? HI : LO;

   // Result datapath evaluated from the operands latched at the start edge.
   always_comb begin
      mul_res = mul_full(a_p0, b_p0, op_p0 == OP_MULT);
      div_res = div_full(a_p0, b_p0, op_p0 == OP_DIV);
   end

   // Stage p0: operand/opcode capture, cycle countdown and HI/LO write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_p0  <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
         cnt_p0 <= '0;
         vld_p0 <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else if (start) begin
         op_p0  <= MDctrl;
         a_p0   <= A;
         b_p0   <= B;
         cnt_p0 <= (MDctrl == OP_MULT || MDctrl == OP_MULTU) ? 4'd5 : 4'd10;
         vld_p0 <= 1'b1;
      end else if (vld_p0) begin
         cnt_p0 <= cnt_p0 - 4'd1;
         if (cnt_p0 == 4'd1) begin
            vld_p0 <= 1'b0;
            if (op_p0 == OP_MULT || op_p0 == OP_MULTU) begin
               HI <= mul_res[2*DATA_W-1:DATA_W];
               LO <= mul_res[DATA_W-1:0];
            end else if (b_p0 != '0) begin
               HI <= div_res[2*DATA_W-1:DATA_W];
               LO <= div_res[DATA_W-1:0];
            end
         end
      end else if (accept && MDctrl == OP_MTHI) begin
         HI <= A;
      end else if (accept && MDctrl == OP_MTLO) begin
         LO <= A;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scenario tasks with a scoreboard of expected {HI,LO} results.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MDctrl;
   logic [31:0] A;
   logic [31:0] B;
   logic        HILOsel;
   logic        md_cancel;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] HILOout;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [63:0] exp_q[$];

   md_unit dut (
      .clk(clk), .reset(reset), .MDctrl(MDctrl), .A(A), .B(B),
      .HILOsel(HILOsel), .md_cancel(md_cancel), .start(start), .busy(busy),
      .HI(HI), .LO(LO), .HILOout(HILOout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hilo);
      MDctrl = op; A = a; B = b;
      #1;
      n_chk++;
      if (start !== 1'b1) $display("FAIL %s_start got %b want 1", nm, start);
      else n_pass++;
      exp_q.push_back(exp_hilo);
      tick;
      MDctrl = 3'b000; A = $urandom; B = $urandom;
   endtask

   task automatic wait_done(input string nm, input int n_exp);
      int          cyc;
      logic [63:0] e;
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
         cyc++;
         tick;
      end
      n_chk++;
      if (cyc !== n_exp) $display("FAIL %s_busy_cycles got %0d want %0d", nm, cyc, n_exp);
      else n_pass++;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s_scoreboard got empty want entry", nm);
      end else begin
         e = exp_q.pop_front();
         if ({HI, LO} !== e) $display("FAIL %s_hilo got %h want %h", nm, {HI, LO}, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; MDctrl = 3'b001; A = 32'hFFFFFFFF; B = 32'h7;
      tick;
      tick;
      reset = 1'b0; MDctrl = 3'b000;
      #1;
      n_chk++;
      if (HI !== 32'h0) $display("FAIL reset_hi got %h want 0", HI); else n_pass++;
      n_chk++;
      if (LO !== 32'h0) $display("FAIL reset_lo got %h want 0", LO); else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_chk++;
      if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start); else n_pass++;
      tick;
   endtask

   task automatic test_mult;
      issue("mult_neg3x5", 3'b001, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
      wait_done("mult_neg3x5", 5);
      issue("multu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      wait_done("multu_max", 5);
      issue("mult_7xneg2", 3'b001, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2);
      wait_done("mult_7xneg2", 5);
   endtask

   task automatic test_div;
      issue("divu_7_2", 3'b100, 32'd7, 32'd2, 64'h00000001_00000003);
      wait_done("divu_7_2", 10);
      issue("div_neg7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
      wait_done("div_neg7_2", 10);
      issue("div_7_neg2", 3'b011, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
      wait_done("div_7_neg2", 10);
      issue("divu_100_7", 3'b100, 32'd100, 32'd7, 64'h00000002_0000000E);
      wait_done("divu_100_7", 10);
   endtask

   task automatic test_mthi_mtlo;
      HILOsel = 1'b0;
      MDctrl = 3'b101; A = 32'h12345678;
      #1;
      n_chk++;
      if (start !== 1'b0) $display("FAIL mthi_start got %b want 0", start); else n_pass++;
      tick;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", busy); else n_pass++;
      MDctrl = 3'b110; A = 32'h9ABCDEF0;
      #1;
      n_chk++;
      if (start !== 1'b0) $display("FAIL mtlo_start got %b want 0", start); else n_pass++;
      tick;
      MDctrl = 3'b000;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", busy); else n_pass++;
      n_chk++;
      if (HI !== 32'h12345678) $display("FAIL mthi_hi got %h want 12345678", HI); else n_pass++;
      n_chk++;
      if (LO !== 32'h9ABCDEF0) $display("FAIL mtlo_lo got %h want 9abcdef0", LO); else n_pass++;
      HILOsel = 1'b1;
      #1;
      n_chk++;
      if (HILOout !== 32'h12345678) $display("FAIL hiloout_hi got %h want 12345678", HILOout);
      else n_pass++;
      HILOsel = 1'b0;
      #1;
      n_chk++;
      if (HILOout !== 32'h9ABCDEF0) $display("FAIL hiloout_lo got %h want 9abcdef0", HILOout);
      else n_pass++;
      tick;
   endtask

   task automatic test_div_zero;
      MDctrl = 3'b101; A = 32'd1;
      tick;
      MDctrl = 3'b110; A = 32'd2;
      tick;
      issue("div_zero", 3'b011, 32'd5, 32'd0, 64'h00000001_00000002);
      tick;
      MDctrl = 3'b010; A = 32'd3; B = 32'd3; HILOsel = 1'b1;
      #1;
      n_chk++;
      if (start !== 1'b0) $display("FAIL multu_while_busy_start got %b want 0", start); else n_pass++;
      n_chk++;
      if (HILOout !== 32'd1) $display("FAIL hiloout_while_busy got %h want 1", HILOout); else n_pass++;
      tick;
      MDctrl = 3'b000; HILOsel = 1'b0;
      wait_done("div_zero", 8);
      tick;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL ignored_multu_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_reset_midop;
      MDctrl = 3'b010; A = 32'h0001_0000; B = 32'h0001_0000;
      tick;
      MDctrl = 3'b000;
      tick;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      n_chk++;
      if ({busy, HI, LO} !== 65'h0) $display("FAIL reset_midop got %h want 0", {busy, HI, LO});
      else n_pass++;
      repeat (6) tick;
      n_chk++;
      if ({busy, HI, LO} !== 65'h0) $display("FAIL no_late_writeback got %h want 0", {busy, HI, LO});
      else n_pass++;
   endtask

   task automatic test_cancel;
      md_cancel = 1'b1; MDctrl = 3'b001; A = 32'hFFFFFFFD; B = 32'h5;
      #1;
`ifdef MD_CANCEL_EN
      n_chk++;
      if (start !== 1'b0) $display("FAIL cancel_start got %b want 0", start); else n_pass++;
      tick;
      MDctrl = 3'b000; md_cancel = 1'b0;
      n_chk++;
      if ({busy, HI, LO} !== 65'h0) $display("FAIL cancel_state got %h want 0", {busy, HI, LO});
      else n_pass++;
`else
      n_chk++;
      if (start !== 1'b1) $display("FAIL cancel_ignored_start got %b want 1", start); else n_pass++;
      exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
      tick;
      MDctrl = 3'b000; md_cancel = 1'b0;
      wait_done("cancel_ignored_mult", 5);
`endif
      issue("mult_cancel_midrun", 3'b001, 32'd6, 32'd7, 64'h00000000_0000002A);
      md_cancel = 1'b1;
      tick;
      md_cancel = 1'b0;
      wait_done("mult_cancel_midrun", 4);
   endtask

   task automatic test_back_to_back;
      issue("b2b_mult", 3'b001, 32'd3, 32'd4, 64'h00000000_0000000C);
      wait_done("b2b_mult", 5);
      issue("b2b_divu", 3'b100, 32'd9, 32'd4, 64'h00000001_00000002);
      wait_done("b2b_divu", 10);
   endtask

   initial begin
      reset = 1'b1; MDctrl = 3'b000; A = '0; B = '0; HILOsel = 1'b0; md_cancel = 1'b0;
      test_reset;
      test_mult;
      test_div;
      test_mthi_mtlo;
      test_div_zero;
      test_reset_midop;
      test_cancel;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 MDctrl  input  3  command: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-004 A  input  32  rs operand (dividend/multiplicand; mthi/mtlo source).
REQ-005 B  input  32  rt operand (divisor/multiplier).
REQ-006 HILOsel  input  1  read select: 1 HI, 0 LO.
REQ-007 md_cancel  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-008 start  output  1  combinational; high when an accepted mult/multu/div/divu is issued this cycle.
REQ-009 busy  output  1  registered; high while an operation is in progress.
REQ-010 HI  output  32  HI register.
REQ-011 LO  output  32  LO register.
REQ-012 HILOout  output  32  combinational, HILOsel ? HI : LO (mfhi/mflo data).

Function
REQ-013 Command accepted only when busy=0 and md_cancel=0 (md_cancel gating subject to REQ-027); otherwise ignored with no state change.
REQ-014 start = accepted command in {001,010,011,100}; start=0 for all other codes.
REQ-015 On start edge: latch A, B and opcode; load counter with 5 (mult/multu) or 10 (div/divu); busy<=1.
REQ-016 busy stays high exactly N cycles following the start cycle (N=5 or 10); counter decrements once per cycle.
REQ-017 At the edge where counter goes 1->0: write HI/LO, busy<=0; new values visible in the same cycle busy is first low.
REQ-018 HI/LO unchanged during an operation until REQ-017 edge; HILOout returns old values while busy.
REQ-019 mult: signed 32x32 to 64-bit product; multu unsigned; HI=product[63:32], LO=product[31:0].
REQ-020 div/divu: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-021 Divide by zero (latched B=0): full 10-cycle busy, HI and LO left unchanged.
REQ-022 mthi/mtlo (accepted): write A into HI or LO at this edge; no busy, start=0.
REQ-023 Any command while busy=1 is ignored; the pipeline stalls on start|busy with mult/div/mfhi/mflo/mthi/mtlo in E.
REQ-024 Operands sampled only at the start edge; later A/B changes do not affect the result.

Reset
REQ-025 reset=1 at an edge: HI=0, LO=0, busy=0, counter=0, latched operands=0; overrides any command or in-flight operation (result discarded).
REQ-026 Cycle after reset deassertion: unit idle and accepts commands.

Configuration
REQ-027 Macro MD_CANCEL_EN: if defined, md_cancel=1 blocks acceptance of any command that cycle (no start, no mthi/mtlo write, already-running operations unaffected); if undefined, md_cancel is ignored and commands are accepted per busy only.

Verification
REQ-028 After reset, mult A=FFFFFFFD (-3), B=00000005 -> start=1 that cycle, busy high 5 cycles, then HI=FFFFFFFF, LO=FFFFFFF1.
REQ-029 divu A=7, B=2 -> busy high 10 cycles, then LO=3, HI=1; div A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-030 mthi A=12345678, next cycle mtlo A=9ABCDEF0 -> HI=12345678, LO=9ABCDEF0, busy never high; HILOsel toggles HILOout accordingly.
REQ-031 HI=1, LO=2 preloaded; div B=0 -> busy 10 cycles, then HI=1, LO=2; multu issued mid-busy is ignored.
REQ-032 multu in progress, reset at cycle 3 -> next cycle HI=0, LO=0, busy=0; no late write-back.
REQ-033 MD_CANCEL_EN defined: mult with md_cancel=1 -> start=0, busy stays 0, HI/LO unchanged; undefined: same stimulus starts the multiply normally.
